// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect,
// and the IR handshake toward decode.
interface instr_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] IR;
   logic [31:0] ir_pc;
   logic        fetch_fault;

   modport master (
      output imem_req_valid, imem_req_addr, ir_valid, IR, ir_pc, fetch_fault,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, ir_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, ir_valid, IR, ir_pc, fetch_fault,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, ir_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: one outstanding word request, wrong-path responses
// drained, fetched word presented as IR/ir_pc over a valid/ready handshake.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, HOLD, FAULT} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_pc, req_pc_n;
   logic [31:0] ir, ir_n;
   logic [31:0] ir_pc, ir_pc_n;
   logic        ir_valid_q, ir_valid_q_n;
   logic        fault, fault_n;
   logic        req_hs;

   assign bus.imem_req_valid = (state == FETCH) && (pc[1:0] == 2'b00);
   assign bus.imem_req_addr  = pc;
   // A redirect kills the held instruction in the same cycle it arrives.
   assign bus.ir_valid       = ir_valid_q && !bus.redirect_valid;
   assign bus.IR             = ir;
   assign bus.ir_pc          = ir_pc;
   assign bus.fetch_fault    = fault;
   assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         req_pc     <= RESET_PC;
         ir         <= 32'h0000_0013;
         ir_pc      <= RESET_PC;
         ir_valid_q <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         req_pc     <= req_pc_n;
         ir         <= ir_n;
         ir_pc      <= ir_pc_n;
         ir_valid_q <= ir_valid_q_n;
         fault      <= fault_n;
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      req_pc_n     = req_pc;
      ir_n         = ir;
      ir_pc_n      = ir_pc;
      ir_valid_q_n = ir_valid_q;
      fault_n      = fault;

      unique case (state)
         IDLE: state_n = FETCH;

         FETCH: begin
            if (pc[1:0] != 2'b00) begin
               fault_n = 1'b1;
               state_n = FAULT;
            end else if (req_hs) begin
               req_pc_n = pc;
               if (bus.redirect_valid) begin
                  pc_n    = bus.redirect_pc;
                  state_n = DRAIN;
               end else begin
                  state_n = WAIT;
               end
            end else if (bus.redirect_valid) begin
               pc_n = bus.redirect_pc;
            end
         end

         WAIT: begin
            if (bus.imem_rsp_valid && !bus.redirect_valid) begin
               ir_n         = bus.imem_rsp_data;
               ir_pc_n      = req_pc;
               ir_valid_q_n = 1'b1;
               pc_n         = req_pc + 32'd4;
               state_n      = HOLD;
            end else if (bus.imem_rsp_valid) begin
               pc_n    = bus.redirect_pc;
               state_n = FETCH;
            end else if (bus.redirect_valid) begin
               pc_n    = bus.redirect_pc;
               state_n = DRAIN;
            end
         end

         // The in-flight response belongs to an abandoned path; swallow it.
         DRAIN: begin
            if (bus.redirect_valid) pc_n = bus.redirect_pc;
            if (bus.imem_rsp_valid) state_n = FETCH;
         end

         HOLD: begin
            if (bus.redirect_valid) begin
               ir_valid_q_n = 1'b0;
               pc_n         = bus.redirect_pc;
               state_n      = FETCH;
            end else if (bus.ir_ready) begin
               ir_valid_q_n = 1'b0;
               state_n      = FETCH;
            end
         end

         FAULT: begin
            ir_valid_q_n = 1'b0;
            if (bus.redirect_valid) begin
               pc_n = bus.redirect_pc;
               if (bus.redirect_pc[1:0] == 2'b00) begin
                  fault_n = 1'b0;
                  state_n = FETCH;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- RV32I instruction fetch stage.
- Holds the PC, issues word requests to instruction memory and captures the returned word.
- Presents the word as IR, with its PC, to the decode/immediate-generation stage over a valid/ready handshake.
- Handles control-flow redirects from execute. At most one memory request is outstanding; wrong-path responses are discarded.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset (must be word aligned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address (word aligned)
imem_rsp_valid  input  1  response data valid (exactly one per accepted request, any latency >=1 cycle)
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  execute requests PC change
redirect_pc  input  32  new PC
ir_valid  output  1  IR/ir_pc valid to decode
ir_ready  input  1  decode accepts IR
IR  output  32  fetched instruction
ir_pc  output  32  PC of IR
fetch_fault  output  1  misaligned PC fault, sticky

Behaviour:
- States: IDLE, FETCH, WAIT, DRAIN, HOLD, FAULT.
- Reset (rst_n=0 at edge):
  - state=IDLE, pc=RESET_PC, req_pc=RESET_PC.
  - IR=32'h0000_0013 (NOP), ir_pc=RESET_PC.
  - ir_valid_q=0, fetch_fault=0.
  - Reset mid-transaction abandons any outstanding request. Memory must not return a response after reset.
- Derived outputs:
  - imem_req_valid = (state==FETCH) & (pc[1:0]==0).
  - imem_req_addr = pc.
  - ir_valid = ir_valid_q & ~redirect_valid (combinational kill of the wrong-path instruction).
- IDLE: next cycle goes to FETCH.
- FETCH:
  - pc[1:0]!=0 → fetch_fault<=1, go to FAULT; no request issued.
  - Handshake (req_valid & req_ready): req_pc<=pc; go to WAIT, or DRAIN if redirect_valid is high the same cycle (pc<=redirect_pc).
  - Redirect without handshake: pc<=redirect_pc, stay in FETCH.
- WAIT:
  - rsp_valid & ~redirect: IR<=rsp_data, ir_pc<=req_pc, ir_valid_q<=1, pc<=req_pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to HOLD.
  - rsp_valid & redirect: data discarded, pc<=redirect_pc, go to FETCH.
  - ~rsp_valid & redirect: pc<=redirect_pc, go to DRAIN.
- DRAIN:
  - rsp_valid: discard data, go to FETCH.
  - redirect: pc<=redirect_pc (last redirect wins); stays in DRAIN unless rsp_valid is high the same cycle.
- HOLD (ir_valid_q=1):
  - redirect: ir_valid_q<=0, pc<=redirect_pc, go to FETCH; no handshake counted.
  - else ir_ready: ir_valid_q<=0, go to FETCH.
  - else: hold IR/ir_pc stable.
- FAULT:
  - No requests; ir_valid_q=0.
  - Redirect to an aligned pc: fetch_fault<=0, pc<=redirect_pc, go to FETCH.
  - Redirect to a misaligned pc: pc updated, stay in FAULT.
- IR/ir_pc change only on a WAIT capture; they are stable while ir_valid=1.
- Latency: FETCH handshake at cycle N, response at N+k → ir_valid at N+k+1.
- Peak throughput: 1 instruction per 3 cycles (zero-wait memory, ir_ready=1).
- Spurious rsp_valid in IDLE/FETCH/HOLD/FAULT is ignored.

Test Plan:
- Reset with RESET_PC=0x100, memory 1-cycle latency, ir_ready=1 → requests at 0x100, 0x104, 0x108; IR/ir_pc pairs match memory; first ir_valid 3 cycles after reset release; IR=0x00000013 during reset.
- Backpressure: hold ir_ready=0 for 5 cycles after IR captured at 0x200 → IR/ir_pc stable, no new imem_req_valid; on release, next request at 0x204.
- Redirect in WAIT with rsp delayed 3 cycles, redirect_pc=0x400 → next response discarded (ir_valid stays 0), next request addr 0x400.
- Redirect in HOLD with ir_ready=1 same cycle, redirect_pc=0x80 → ir_valid=0 that cycle, next request addr 0x80, old IR never accepted.
- Redirect to 0x402 → fetch_fault=1, no requests; later redirect to 0x500 → fault clears, request at 0x500.
- Wrap: redirect to 0xFFFF_FFFC → after capture, next request addr 0x0000_0000.
